// File: rtl/rom_fetch_queue.sv
// rom_fetch_queue: owns the fetch PC, drives the ROM address and buffers fetched
// bytes in a prefetch FIFO that feeds the decoder over a valid/ready handshake.
module rom_fetch_queue #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    QUEUE_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    DATA_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    output logic [ADDR_WIDTH-1:0]          rom_address,
    input  logic [DATA_WIDTH-1:0]          rom_data,
    output logic                           instr_valid,
    output logic [DATA_WIDTH-1:0]          instr_byte,
    output logic [ADDR_WIDTH-1:0]          instr_addr,
    input  logic                           instr_ready,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_addr,
    input  logic                           fetch_halt,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    logic [EW-1:0]         mem_q [QUEUE_DEPTH];
    logic [EW-1:0]         mem_d [QUEUE_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [EW-1:0]         last_q, last_d;
    logic [EW-1:0]         head;
    logic                  pop, push;

    // When empty the head outputs hold the last entry presented rather than stale storage
    assign head        = count_q != '0 ? mem_q[rd_ptr_q] : last_q;
    assign instr_valid = count_q != '0;
    assign {instr_byte, instr_addr} = head;
    assign rom_address = pc_q;
    assign queue_count = count_q;
    assign pop  = instr_valid & instr_ready;
    assign push = !redirect_valid & !fetch_halt & (count_q < FULL | pop);

    always_comb begin
        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = {rom_data, pc_q};
        wr_ptr_d = redirect_valid ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
        count_d  = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        pc_d     = redirect_valid ? redirect_addr : pc_q + ADDR_WIDTH'(push);
        last_d   = head;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_VECTOR;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            last_q   <= last_d;
        end
    end
endmodule

// File: tb/tb_rom_fetch_queue.sv
// tb_rom_fetch_queue: directed scenarios plus random traffic against a queue-based
// reference model of the fetch queue.
module tb_rom_fetch_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rom_address;
    logic [7:0]  rom_data;
    logic        instr_valid;
    logic [7:0]  instr_byte;
    logic [11:0] instr_addr;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_addr = '0;
    logic        fetch_halt = 1'b0;
    logic [2:0]  queue_count;

    logic [7:0]  rom [4096];
    int          total = 0;
    int          bad = 0;
    int          q[$];
    int          pc = 0;

    assign rom_data = rom[rom_address];
    always #5 clk = ~clk;

    rom_fetch_queue dut (
        .clk(clk), .reset_n(reset_n), .rom_address(rom_address), .rom_data(rom_data),
        .instr_valid(instr_valid), .instr_byte(instr_byte), .instr_addr(instr_addr),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .fetch_halt(fetch_halt), .queue_count(queue_count)
    );

    task automatic chk(string tag, logic [31:0] obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 0);
        chk({tag, "_count"}, 32'(queue_count), 0);
        chk({tag, "_byte"}, 32'(instr_byte), 0);
        chk({tag, "_addr"}, 32'(instr_addr), 0);
        chk({tag, "_rom_address"}, 32'(rom_address), 0);
    endtask

    // Called one time unit after a rising edge; drives, checks, advances model and clock
    task automatic cyc(bit rdy, bit redir, int raddr, bit halt);
        bit mvalid, mpop, mpush;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_addr  = raddr[11:0];
        fetch_halt     = halt;
        #3;
        mvalid = q.size() > 0;
        chk("rom_address", 32'(rom_address), pc);
        chk("queue_count", 32'(queue_count), q.size());
        chk("instr_valid", 32'(instr_valid), int'(mvalid));
        if (mvalid) begin
            chk("instr_addr", 32'(instr_addr), q[0]);
            chk("instr_byte", 32'(instr_byte), int'(rom[q[0]]));
        end
        mpop = mvalid && rdy;
        if (redir) begin
            q.delete();
            pc = raddr % 4096;
        end else begin
            mpush = !halt && (q.size() < 4 || mpop);
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                q.push_back(pc);
                pc = (pc + 1) % 4096;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the immediate effect, releases one cycle later
    task automatic mid_reset(string tag);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_state(tag);
        q.delete();
        pc = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            rom[i] = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        chk_reset_state("por");
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0);

        mid_reset("rst_a");
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        mid_reset("rst_b");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 12'hFFE, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

        mid_reset("rst_c");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 1, 12'h7A5, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            int ra;
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(4090, 4095))
                                             : int'($urandom_range(0, 4095));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, ra,
                $urandom_range(0, 9) == 0);
        end

        mid_reset("rst_d");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
